tt_vector_runner: RTL and testbench
===================================

# tt_vector_runner

On-chip stimulus/response sequencer that sits directly upstream and downstream of the 8-bit `io_in`/`io_out` design wrapper. It stores up to `DEPTH` input/expected-output vector pairs. On `start` it applies each input to the wrapper and holds it for a programmable settle time. It then samples the wrapper output, compares it with the expected value, and reports pass/fail, an error count and the first failing vector. It is the hardware form of our directed bench, used for bring-up when no simulator is in the loop.

## Interface
Parameters:
- `DEPTH`, 8: number of vector slots; power of two, ≥2.
- `SETTLE`, 10: clock cycles each vector is held before its output is sampled; ≥1.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: empties the vector store; honoured only in IDLE/DONE.
- `load_valid` in 1: a vector pair is presented.
- `load_ready` out 1: store can accept a pair.
- `load_in` in 8: stimulus byte.
- `load_exp` in 8: expected response byte.
- `start` in 1: single-cycle run request.
- `busy` out 1: run in progress.
- `done` out 1: last run finished; held until next `start`, `clear` or `reset`.
- `pass` out 1: valid when `done`; 1 iff `err_count == 0`.
- `err_count` out `$clog2(DEPTH+1)`: mismatches in last run.
- `fail_idx` out `$clog2(DEPTH)`: index of first mismatch.
- `fail_actual` out 8: `dut_out` captured at first mismatch.
- `dut_in` out 8: registered drive to wrapper `io_in`.
- `dut_out` in 8: wrapper `io_out`.

## Operation
- Reset: state IDLE, `vec_count=0`, `dut_in=0`, `busy=done=pass=0`, `err_count=fail_idx=fail_actual=0`. Memory contents are don't-care.
- States: IDLE, RUN, DONE.
- Load (IDLE or DONE): `load_ready = (vec_count < DEPTH) && state != RUN`. A handshake writes slot `vec_count` and increments it. When full, `load_ready=0` and further `load_valid` is ignored.
- `clear` in IDLE/DONE sets `vec_count=0`, `done=0` and returns to IDLE. It is ignored in RUN. If `clear` and `load_valid` occur in the same cycle, `clear` wins and the load is dropped.
- `start` in IDLE/DONE with `vec_count=0` goes to DONE next cycle with `pass=1`, `err_count=0`.
- `start` in IDLE/DONE with `vec_count=n>0`:
  - clears `err_count`, `fail_*` and `done`;
  - sets `idx=0`, `dut_in<=vec_in[0]`, settle counter `=SETTLE-1`;
  - enters RUN.
- `start` while in RUN is ignored. `start` together with `clear` means `clear` wins.
- RUN: the counter decrements each cycle. On the cycle it reads 0:
  - compare `dut_out` with `vec_exp[idx]`;
  - on mismatch, `err_count++`; if this is the first mismatch, latch `fail_idx=idx` and `fail_actual=dut_out`;
  - if `idx==n-1`, go to DONE;
  - otherwise `idx++`, load the next `dut_in` and reload the counter.
- DONE: `dut_in` holds the last vector. `done=1`. `pass=(err_count==0)`.
- `err_count` cannot overflow; its width covers `DEPTH`.
- Reset mid-run aborts the run immediately to reset values.

## Timing
- `dut_in` changes on the edge that accepts `start`, then every `SETTLE` cycles.
- Vector k's output is sampled exactly `SETTLE` cycles after `dut_in` took vector k.
- `busy` is high from the cycle after `start` through the final compare edge.
- `done` rises on the final compare edge. Total: `n*SETTLE` cycles from the start edge to `done`.
- `load_ready` depends on registered state only, with no combinational path from `load_valid`.
- `dut_out` is sampled synchronously. The wrapper path must settle within `SETTLE` cycles.

## Structure
- Shared package `tt_bench_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - `IO_W=8`;
  - the vector-pair struct `{in, exp}`.
- One natural sub-module, `tt_vector_store`: a `DEPTH`×16 register file with a write port and one async read port indexed by `idx`.
- Control FSM, settle counter and scoreboard live in the top.

## Test plan
- Loopback (`dut_out=dut_in`), load 8 pairs with `exp=in` (`05`, `30`, `4D`, `61`, `9C`, `A3`, `CB`, `FB`), start → `done` after 8·`SETTLE` cycles, `pass=1`, `err_count=0`.
- Same loopback, slot 2 `exp=80` and slot 6 `exp=E0` → `err_count=2`, `fail_idx=2`, `fail_actual=4D`, `pass=0`.
- Load 9 pairs with `DEPTH=8` → 9th handshake refused (`load_ready=0` after 8th), run checks exactly 8.
- `start` with empty store → `done=1`, `pass=1` one cycle later; `clear` in RUN ignored; `start` in RUN ignored.
- Assert `reset` at vector 3 of a run → next cycle all outputs zero, `vec_count=0`; reload 1 pair and run → `done` after `SETTLE` cycles.
- `SETTLE=1`, wrapper adds one register stage → every vector mismatches (`err_count=n`); `SETTLE=2` → `pass=1`.

Source files
------------

// File: rtl/tt_bench_pkg.sv
// Shared types for the on-chip vector runner: run state, IO width, vector pair.
// No logic, types only.
// No flow control here; consumers define handshakes.
package tt_bench_pkg;

    localparam int IO_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

    typedef struct packed {
        logic [IO_W-1:0] in;
        logic [IO_W-1:0] exp;
    } vec_pair_t;

endpackage

// File: rtl/tt_vector_store.sv
// Vector pair register file: one write port, one async read port.
// Write lands on the clock edge; read is combinational from idx.
// No backpressure; the caller gates wr_en.
module tt_vector_store
    import tt_bench_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  vec_pair_t                wr_dat,
    input  logic [$clog2(DEPTH)-1:0] idx,
    output vec_pair_t                rd_dat
);

    vec_pair_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[idx];

endmodule

// File: rtl/tt_vector_runner.sv
// Stimulus/response sequencer: drives stored vectors into the wrapper and scores its output.
// Each vector is held SETTLE cycles; n vectors complete n*SETTLE cycles after start.
// load_ready drops when the store is full or a run is in progress.
module tt_vector_runner
    import tt_bench_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [IO_W-1:0]            load_in,
    input  logic [IO_W-1:0]            load_exp,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH+1)-1:0] err_count,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [IO_W-1:0]            fail_actual,
    output logic [IO_W-1:0]            dut_in,
    input  logic [IO_W-1:0]            dut_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    run_state_e      state_q, state_d;
    logic [CW-1:0]   vec_count_q, vec_count_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [IO_W-1:0] dut_in_q, dut_in_d;
    logic [IO_W-1:0] exp_q, exp_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic [IW-1:0]   fail_idx_q, fail_idx_d;
    logic [IO_W-1:0] fail_actual_q, fail_actual_d;

    logic            wr_en;
    logic [IW-1:0]   rd_idx;
    vec_pair_t       rd_vec;

    tt_vector_store #(.DEPTH(DEPTH)) u_store (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (vec_count_q[IW-1:0]),
        .wr_dat ({load_in, load_exp}),
        .idx    (rd_idx),
        .rd_dat (rd_vec)
    );

    assign load_ready = (vec_count_q < CW'(DEPTH)) && (state_q != RUN);

    always_comb begin
        state_d       = state_q;
        vec_count_d   = vec_count_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        dut_in_d      = dut_in_q;
        exp_d         = exp_q;
        done_d        = done_q;
        pass_d        = pass_q;
        err_count_d   = err_count_q;
        fail_idx_d    = fail_idx_q;
        fail_actual_d = fail_actual_q;
        wr_en         = 1'b0;
        rd_idx        = idx_q;

        case (state_q)
            RUN: begin
                if (cnt_q == '0) begin
                    if (dut_out != exp_q) begin
                        err_count_d = err_count_q + CW'(1);
                        if (err_count_q == '0) begin
                            fail_idx_d    = idx_q;
                            fail_actual_d = dut_out;
                        end
                    end
                    if (CW'(idx_q) == vec_count_q - CW'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        // Expected byte travels with the stimulus so one read port suffices.
                        idx_d    = idx_q + IW'(1);
                        rd_idx   = idx_d;
                        dut_in_d = rd_vec.in;
                        exp_d    = rd_vec.exp;
                        cnt_d    = SW'(SETTLE - 1);
                    end
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            default: begin
                if (clear) begin
                    state_d     = IDLE;
                    vec_count_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end else begin
                    if (load_valid && load_ready) begin
                        wr_en       = 1'b1;
                        vec_count_d = vec_count_q + CW'(1);
                    end
                    if (start) begin
                        err_count_d   = '0;
                        fail_idx_d    = '0;
                        fail_actual_d = '0;
                        if (vec_count_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end else begin
                            state_d  = RUN;
                            done_d   = 1'b0;
                            pass_d   = 1'b0;
                            idx_d    = '0;
                            rd_idx   = '0;
                            dut_in_d = rd_vec.in;
                            exp_d    = rd_vec.exp;
                            cnt_d    = SW'(SETTLE - 1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            vec_count_q   <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            dut_in_q      <= '0;
            exp_q         <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_count_q   <= '0;
            fail_idx_q    <= '0;
            fail_actual_q <= '0;
        end else begin
            state_q       <= state_d;
            vec_count_q   <= vec_count_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            dut_in_q      <= dut_in_d;
            exp_q         <= exp_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_count_q   <= err_count_d;
            fail_idx_q    <= fail_idx_d;
            fail_actual_q <= fail_actual_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_count_q;
    assign fail_idx    = fail_idx_q;
    assign fail_actual = fail_actual_q;
    assign dut_in      = dut_in_q;

endmodule

// File: tb/tb_tt_vector_runner.sv
// Bench for tt_vector_runner: loopback DUT at SETTLE=10 plus two DUTs behind a
// one-register wrapper at SETTLE=1 and SETTLE=2, all sharing the control inputs.
module tb_tt_vector_runner;

    localparam int S = 10;

    typedef struct {
        logic       pass;
        int         err;
        int         idx;
        logic [7:0] act;
    } exp_t;

    typedef struct {
        int         n;
        int         ia;
        logic [7:0] va;
        int         ib;
        logic [7:0] vb;
        logic       exp_pass;
        int         exp_err;
        int         exp_idx;
        logic [7:0] exp_act;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_in = '0;
    logic [7:0] load_exp = '0;
    logic       start = 1'b0;

    logic       load_ready, busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] fail_idx;
    logic [7:0] fail_actual, dut_in;

    logic       s1_rdy, s1_busy, s1_done, s1_pass;
    logic [3:0] s1_err;
    logic [2:0] s1_fidx;
    logic [7:0] s1_fact, s1_in, s1_out;
    logic       s2_rdy, s2_busy, s2_done, s2_pass;
    logic [3:0] s2_err;
    logic [2:0] s2_fidx;
    logic [7:0] s2_fact, s2_in, s2_out;

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];
    logic [7:0] vecs [8];
    rec_t tbl [5];
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    tt_vector_runner #(.DEPTH(8), .SETTLE(S)) u_dut (
        .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_ready(load_ready), .load_in(load_in), .load_exp(load_exp),
        .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx), .fail_actual(fail_actual),
        .dut_in(dut_in), .dut_out(dut_in)
    );

    tt_vector_runner #(.DEPTH(8), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_ready(s1_rdy), .load_in(load_in), .load_exp(load_exp),
        .start(start), .busy(s1_busy), .done(s1_done), .pass(s1_pass),
        .err_count(s1_err), .fail_idx(s1_fidx), .fail_actual(s1_fact),
        .dut_in(s1_in), .dut_out(s1_out)
    );

    tt_vector_runner #(.DEPTH(8), .SETTLE(2)) u_s2 (
        .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_ready(s2_rdy), .load_in(load_in), .load_exp(load_exp),
        .start(start), .busy(s2_busy), .done(s2_done), .pass(s2_pass),
        .err_count(s2_err), .fail_idx(s2_fidx), .fail_actual(s2_fact),
        .dut_in(s2_in), .dut_out(s2_out)
    );

    // Wrapper model with one register stage.
    always @(posedge clk) begin
        if (reset) begin
            s1_out <= '0;
            s2_out <= '0;
        end else begin
            s1_out <= s1_in;
            s2_out <= s2_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pass", pass, e.pass);
                chk("sb_err_count", err_count, e.err);
                chk("sb_fail_idx", fail_idx, e.idx);
                chk("sb_fail_actual", fail_actual, e.act);
            end
        end
        done_prev <= done;
    end

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic load_pair(input logic [7:0] vi, input logic [7:0] ve, inout int acc);
        chk("load_ready", load_ready, acc < 8);
        load_valid = 1'b1;
        load_in    = vi;
        load_exp   = ve;
        if (load_ready) acc++;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_and_wait(input exp_t e, input int n);
        int cyc = 0;
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, n > 0);
        wait_done(cyc);
        chk("run_cycles", cyc, n * S);
    endtask

    initial begin
        int acc;
        int cyc;
        exp_t e;
        vecs = '{8'h05, 8'h30, 8'h4D, 8'h61, 8'h9C, 8'hA3, 8'hCB, 8'hFB};
        tbl[0] = '{8, -1, 8'h00, -1, 8'h00, 1'b1, 0, 0, 8'h00};
        tbl[1] = '{8,  2, 8'h80,  6, 8'hE0, 1'b0, 2, 2, 8'h4D};
        tbl[2] = '{9, -1, 8'h00, -1, 8'h00, 1'b1, 0, 0, 8'h00};
        tbl[3] = '{3,  1, 8'h00, -1, 8'h00, 1'b0, 1, 1, 8'h30};
        tbl[4] = '{2,  0, 8'hFF,  1, 8'h00, 1'b0, 2, 0, 8'h05};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fidx", fail_idx, 0);
        chk("rst_fact", fail_actual, 0);
        chk("rst_dut_in", dut_in, 0);
        chk("rst_load_ready", load_ready, 1);

        // Registered wrapper: SETTLE=1 always sees the previous vector, SETTLE=2 sees the right one.
        acc = 0;
        for (int i = 0; i < 8; i++) load_pair(vecs[i], vecs[i], acc);
        run_and_wait('{1'b1, 0, 0, 8'h00}, 8);
        chk("s1_done", s1_done, 1);
        chk("s1_err", s1_err, 8);
        chk("s1_pass", s1_pass, 0);
        chk("s1_fidx", s1_fidx, 0);
        chk("s1_fact", s1_fact, 8'h00);
        chk("s2_done", s2_done, 1);
        chk("s2_err", s2_err, 0);
        chk("s2_pass", s2_pass, 1);

        for (int r = 0; r < 5; r++) begin
            int n_acc;
            pulse_clear();
            chk("clear_done", done, 0);
            acc = 0;
            for (int i = 0; i < tbl[r].n; i++) begin
                logic [7:0] vi;
                logic [7:0] ve;
                vi = (i < 8) ? vecs[i] : 8'h11;
                ve = vi;
                if (i == tbl[r].ia) ve = tbl[r].va;
                if (i == tbl[r].ib) ve = tbl[r].vb;
                load_pair(vi, ve, acc);
            end
            n_acc = (tbl[r].n > 8) ? 8 : tbl[r].n;
            chk("accepted", acc, n_acc);
            e = '{tbl[r].exp_pass, tbl[r].exp_err, tbl[r].exp_idx, tbl[r].exp_act};
            run_and_wait(e, n_acc);
            chk("dut_in_hold", dut_in, vecs[n_acc-1]);
        end

        // Empty store.
        pulse_clear();
        run_and_wait('{1'b1, 0, 0, 8'h00}, 0);
        chk("empty_done", done, 1);
        chk("empty_pass", pass, 1);

        // clear and start during RUN have no effect.
        pulse_clear();
        acc = 0;
        for (int i = 0; i < 3; i++) load_pair(vecs[i], vecs[i], acc);
        sb_q.push_back('{1'b1, 0, 0, 8'h00});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        repeat (4) begin @(negedge clk); cyc++; end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        cyc++;
        chk("busy_after_clear", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        chk("busy_after_start_in_run", busy, 1);
        wait_done(cyc);
        chk("run_ignore_cycles", cyc, 3 * S);

        // Reset during vector 3.
        pulse_clear();
        acc = 0;
        for (int i = 0; i < 8; i++) load_pair(vecs[i], vecs[i], acc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * S + 2) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_dut_in", dut_in, vecs[3]);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_count, 0);
        chk("abort_dut_in", dut_in, 0);
        chk("abort_load_ready", load_ready, 1);
        acc = 0;
        load_pair(8'h5A, 8'h5A, acc);
        run_and_wait('{1'b1, 0, 0, 8'h00}, 1);
        chk("reload_dut_in", dut_in, 8'h5A);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
